// File: rtl/width_conv_pkg.sv
// Shared definitions for the narrow/wide width-conversion path.
// The packer and the downstream unpacker both use these.
package width_conv_pkg;

    typedef enum logic [1:0] {
        EMPTY      = 2'd0,
        FILLING    = 2'd1,
        FLUSH_PEND = 2'd2
    } acc_state_e;

    // Width of a lane count that must represent 0..ratio inclusive.
    function automatic int lane_count_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/fifo_width_packer.sv
// Packs RATIO narrow beats (little-endian) into one wide FIFO word.
// Accumulator plus hold register let the stream keep flowing while a word waits on a full FIFO.
module fifo_width_packer
    import width_conv_pkg::*;
#(
    parameter  int IN_WIDTH  = 8,
    parameter  int RATIO     = 4,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int CNT_W     = lane_count_width(RATIO)
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    input  logic                 fifo_full_i,
    output logic                 fifo_write_o,
    output logic [OUT_WIDTH-1:0] fifo_wdata_o,
    output logic [CNT_W-1:0]     fifo_wcount_o
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    acc_state_e           state_q, state_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] hold_q;
    logic [CNT_W-1:0]     hold_cnt_q;
    logic                 hold_valid_q;

    logic                 drain_s;
    logic                 hold_free_s;
    logic                 pend_s;
    logic                 accept_s;
    logic [CNT_W-1:0]     idx_inc_s;
    logic [OUT_WIDTH-1:0] acc_ins_s;
    logic                 load_s;
    logic [OUT_WIDTH-1:0] load_data_s;
    logic [CNT_W-1:0]     load_cnt_s;

    // Handshake and drain decode; ready depends combinationally on the FIFO full flag.
    always_comb begin
        drain_s     = hold_valid_q & ~fifo_full_i;
        hold_free_s = ~hold_valid_q | drain_s;
        pend_s      = (state_q == FLUSH_PEND);
        in_ready_o  = ~(((idx_q == LAST_IDX) | pend_s) & ~hold_free_s);
        accept_s    = in_valid_i & in_ready_o;
        idx_inc_s   = idx_q + {{(CNT_W-1){1'b0}}, accept_s};
    end

    // Accumulator image with the accepted beat dropped into lane idx_q.
    always_comb begin
        acc_ins_s = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            acc_ins_s[k*IN_WIDTH +: IN_WIDTH] = (accept_s && (idx_q == CNT_W'(k)))
                                              ? in_data_i
                                              : acc_q[k*IN_WIDTH +: IN_WIDTH];
        end
    end

    // Accumulator next state and hold-register load decision.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        load_s      = 1'b0;
        load_data_s = acc_q;
        load_cnt_s  = idx_q;
        case (state_q)
            FLUSH_PEND: begin
                // Flush requests are ignored here; a beat taken in the transfer cycle starts a fresh word.
                if (hold_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = acc_q;
                    load_cnt_s  = idx_q;
                    acc_d       = accept_s ? OUT_WIDTH'(in_data_i) : {OUT_WIDTH{1'b0}};
                    idx_d       = accept_s ? CNT_ONE : CNT_ZERO;
                    state_d     = accept_s ? FILLING : EMPTY;
                end else begin
                    state_d     = FLUSH_PEND;
                end
            end
            EMPTY, FILLING: begin
                if (accept_s && (idx_q == LAST_IDX)) begin
                    load_s      = 1'b1;
                    load_data_s = acc_ins_s;
                    load_cnt_s  = FULL_CNT;
                    acc_d       = {OUT_WIDTH{1'b0}};
                    idx_d       = CNT_ZERO;
                    state_d     = EMPTY;
                end else if (flush_i && (idx_inc_s != CNT_ZERO)) begin
                    if (hold_free_s) begin
                        load_s      = 1'b1;
                        load_data_s = acc_ins_s;
                        load_cnt_s  = idx_inc_s;
                        acc_d       = {OUT_WIDTH{1'b0}};
                        idx_d       = CNT_ZERO;
                        state_d     = EMPTY;
                    end else begin
                        acc_d       = acc_ins_s;
                        idx_d       = idx_inc_s;
                        state_d     = FLUSH_PEND;
                    end
                end else begin
                    acc_d   = acc_ins_s;
                    idx_d   = idx_inc_s;
                    state_d = (idx_inc_s == CNT_ZERO) ? EMPTY : FILLING;
                end
            end
            default: begin
                acc_d   = {OUT_WIDTH{1'b0}};
                idx_d   = CNT_ZERO;
                state_d = EMPTY;
            end
        endcase
    end

    // Accumulator state register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= EMPTY;
            idx_q   <= CNT_ZERO;
            acc_q   <= {OUT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    // Hold register: a new load wins over the drain of the previous word on the same edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hold_q       <= {OUT_WIDTH{1'b0}};
            hold_cnt_q   <= CNT_ZERO;
            hold_valid_q <= 1'b0;
        end else if (load_s) begin
            hold_q       <= load_data_s;
            hold_cnt_q   <= load_cnt_s;
            hold_valid_q <= 1'b1;
        end else if (drain_s) begin
            hold_valid_q <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_q;
        end
    end

    assign fifo_write_o  = drain_s;
    assign fifo_wdata_o  = hold_q;
    assign fifo_wcount_o = hold_cnt_q;

endmodule

// File: tb/tb_fifo_width_packer.sv
// Directed, table-driven bench for fifo_width_packer (IN_WIDTH=8, RATIO=4).
module tb_fifo_width_packer;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [7:0]  in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        flush_i;
    logic        fifo_full_i;
    logic        fifo_write_o;
    logic [31:0] fifo_wdata_o;
    logic [2:0]  fifo_wcount_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    fifo_width_packer #(.IN_WIDTH(8), .RATIO(4)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .flush_i      (flush_i),
        .fifo_full_i  (fifo_full_i),
        .fifo_write_o (fifo_write_o),
        .fifo_wdata_o (fifo_wdata_o),
        .fifo_wcount_o(fifo_wcount_o)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        fl;
        logic        fu;
        logic        e_rdy;
        logic        e_wr;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic fl, logic fu,
                                logic e_rdy, logic e_wr, logic [31:0] e_data, logic [2:0] e_cnt);
        vec_t r;
        r.v = v; r.d = d; r.fl = fl; r.fu = fu;
        r.e_rdy = e_rdy; r.e_wr = e_wr; r.e_data = e_data; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic fl, input logic fu);
        @(negedge clk_i);
        in_valid_i  = v;
        in_data_i   = d;
        flush_i     = fl;
        fifo_full_i = fu;
        #2;
    endtask

    int writes;

    initial begin
        reset_ni = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00; flush_i = 1'b0; fifo_full_i = 1'b0;

        // Scenario 1: reset values.
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        #2;
        chk("rst_write", {31'd0, fifo_write_o}, 32'd0);
        chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
        chk("rst_wcount", {29'd0, fifo_wcount_o}, 32'd0);

        // Asynchronous reset while a word is being written.
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        drive(1'b1, 8'h03, 1'b0, 1'b0);
        drive(1'b1, 8'h04, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_async_write", {31'd0, fifo_write_o}, 32'd1);
        reset_ni = 1'b0;
        #1;
        chk("async_write", {31'd0, fifo_write_o}, 32'd0);
        chk("async_wcount", {29'd0, fifo_wcount_o}, 32'd0);
        chk("async_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk_i);
        reset_ni = 1'b1;

        // Scenario 2: back-to-back words.
        vecs.push_back(mk(1, 8'h11, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h22, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h33, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h44, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 32'h44332211, 3'd4));
        vecs.push_back(mk(1, 8'h51, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h52, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h53, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h54, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h55, 0, 0, 1, 1, 32'h54535251, 3'd4));
        vecs.push_back(mk(1, 8'h56, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h57, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h58, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 32'h58575655, 3'd4));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'h0, 3'd0));
        // Scenario 3: full FIFO back-pressure.
        vecs.push_back(mk(1, 8'h01, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h03, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h04, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h05, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h06, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h07, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h08, 0, 1, 0, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h08, 0, 1, 0, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h08, 0, 0, 1, 1, 32'h04030201, 3'd4));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 32'h08070605, 3'd4));
        // Scenario 4: flush of a partial word, then flush while empty.
        vecs.push_back(mk(1, 8'hAA, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'hBB, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 32'h0000BBAA, 3'd2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'h0, 3'd0));
        // Scenario 5a: flush together with an accepted beat.
        vecs.push_back(mk(1, 8'hAA, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'hBB, 0, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'hCC, 1, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 32'h00CCBBAA, 3'd3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'h0, 3'd0));
        // Scenario 5b: flush while the hold register is occupied and the FIFO is full.
        vecs.push_back(mk(1, 8'h01, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h03, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h04, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h22, 0, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h99, 1, 1, 0, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h99, 0, 1, 0, 0, 32'h0, 3'd0));
        vecs.push_back(mk(1, 8'h99, 0, 0, 1, 1, 32'h04030201, 3'd4));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 32'h00002211, 3'd2));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 32'h0, 3'd0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 32'h00000099, 3'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'h0, 3'd0));

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].fl, vecs[i].fu);
            chk($sformatf("vec%0d_ready", i), {31'd0, in_ready_o}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_write", i), {31'd0, fifo_write_o}, {31'd0, vecs[i].e_wr});
            if (vecs[i].e_wr) begin
                chk($sformatf("vec%0d_wdata", i), fifo_wdata_o, vecs[i].e_data);
                chk($sformatf("vec%0d_wcount", i), {29'd0, fifo_wcount_o}, {29'd0, vecs[i].e_cnt});
            end
        end

        // Scenario 6: reset mid-word discards the partial data.
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        drive(1'b1, 8'h34, 1'b0, 1'b0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        reset_ni   = 1'b0;
        #2;
        chk("midword_rst_wcount", {29'd0, fifo_wcount_o}, 32'd0);
        reset_ni = 1'b1;
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        chk("post_rst_b0_write", {31'd0, fifo_write_o}, 32'd0);
        drive(1'b1, 8'h66, 1'b0, 1'b0);
        chk("post_rst_b1_write", {31'd0, fifo_write_o}, 32'd0);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_rst_b2_write", {31'd0, fifo_write_o}, 32'd0);
        drive(1'b1, 8'h88, 1'b0, 1'b0);
        chk("post_rst_b3_write", {31'd0, fifo_write_o}, 32'd0);
        writes = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            if (fifo_write_o) begin
                writes++;
                chk("post_rst_wdata", fifo_wdata_o, 32'h88776655);
                chk("post_rst_wcount", {29'd0, fifo_wcount_o}, 32'd4);
            end
        end
        chk("post_rst_write_count", writes, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
